strela_mem_arbiter: RTL and testbench
=====================================

// Module: strela_mem_arbiter
// PURPOSE
// Round-robin arbiter that shares one OBI memory port among the STRELA memory masters: the configuration loader, the IMNs and the OMNs.
// Grants one request per accepted handshake and holds a stalled request until the slave grants it, as OBI requires.
// Records the order of granted requests and returns each response to the master that issued it.
// Sits between the per-node obi_req_t/obi_resp_t arrays, which the perf counters also watch, and the single bus master port.
// PARAMETERS
// NUM_MASTERS      NODES  number of requesting masters; index 0 has the highest priority after reset
// MAX_OUTSTANDING  2      granted transactions that may wait for rvalid at once; power of 2, >=1
// PORTS
// clk_i            in   1                        clock
// rst_ni           in   1                        asynchronous active-low reset
// masters_req_i    in   obi_req_t [NUM_MASTERS]  per-master OBI request (req, we, be, addr, wdata)
// masters_resp_o   out  obi_resp_t[NUM_MASTERS]  per-master OBI response (gnt, rvalid, rdata)
// slave_req_o      out  obi_req_t                request to the shared memory port
// slave_resp_i     in   obi_resp_t               response from the shared memory port
// outstanding_o    out  $clog2(MAX_OUTSTANDING)+1 granted transactions still waiting for rvalid
// rsp_err_o        out  1                        sticky flag: rvalid arrived with no transaction outstanding
// BEHAVIOUR
// - Reset: rr pointer=0, lock=0, locked index=0, ID FIFO empty (outstanding_o=0), rsp_err_o=0.
// - Combinational outputs depend only on inputs and on registers that hold their reset values while reset is asserted.
// - can_issue = (outstanding count < MAX_OUTSTANDING). Full blocks new issues even when a pop happens in the same cycle; there is no bypass.
// - Selection, when lock=0: first master with req=1, searching from the rr pointer upward with wrap-around.
// - Selection, when lock=1: the locked index is forced, whatever the priority.
// - slave_req_o = selected master's request when can_issue and that master has req=1; otherwise all fields 0.
// - Grant: masters_resp_o[sel].gnt = slave_resp_i.gnt while slave_req_o.req=1. The gnt of every other master is 0.
//   Grant-to-master is combinational, zero added latency.
// - Handshake (slave req & gnt):
//   - push sel into the ID FIFO;
//   - rr pointer <= (sel+1) mod NUM_MASTERS;
//   - lock <= 0.
// - Stall (slave req & !gnt): lock <= 1 and locked index <= sel, so req and address stay stable until gnt.
//   - If the locked master drops req (illegal OBI), lock <= 0 on the next edge.
// - Response: on slave_resp_i.rvalid the ID FIFO head h selects the receiver.
//   - masters_resp_o[h].rvalid=1 and masters_resp_o[h].rdata = slave rdata, same cycle.
//   - The ID FIFO pops on the same edge.
//   - rdata goes to every master; rvalid goes only to h.
// - Push and pop in the same cycle: count unchanged, FIFO pointers both advance.
// - rvalid with an empty FIFO: no master rvalid, no pop, rsp_err_o <= 1 until reset.
// - Write transactions also wait for rvalid; OBI returns a response for every granted request.
// - Mid-operation reset clears all state at once. Any transactions in flight are dropped, and their later rvalid sets rsp_err_o.
// - Arithmetic: the pointer and FIFO indices wrap modulo their sizes. The count uses $clog2(MAX_OUTSTANDING)+1 bits and never exceeds MAX_OUTSTANDING.
// TESTING
// - Masters 0,2,5 hold req, slave gnt=1 every cycle -> grant order 0,2,5,0,2,5; rr pointer goes 1,3,6,1.
// - Master 3 requests at addr 0x100 with slave gnt=0 for 4 cycles while master 1 raises req ->
//   slave_req_o keeps addr 0x100 from master 3, and master 1 is granted only after master 3.
// - MAX_OUTSTANDING=2, two grants, no rvalid -> outstanding_o=2 and slave_req_o.req=0.
//   One rvalid -> next cycle a new request is issued.
// - Grants to masters 4 then 1, then two rvalid with rdata 0xAAAA, 0xBBBB ->
//   master 4 receives 0xAAAA, master 1 receives 0xBBBB, outstanding_o returns to 0.
// - Grant and rvalid in the same cycle with outstanding_o=1 -> outstanding_o stays 1, and the old head is delivered.
// - rvalid with outstanding_o=0 -> rsp_err_o=1 and stays set. Assert rst_ni mid-burst -> all state cleared and rsp_err_o=0.

Source files
------------

// File: rtl/strela_mem_arbiter_if.sv
// OBI request/response payloads and the bundle that connects the memory masters and the shared port to the arbiter.
// The arbiter uses the slave modport; the master modport is the view from the masters and the memory.
package strela_obi_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic              gnt;
        logic              rvalid;
        logic [DATA_W-1:0] rdata;
    } obi_resp_t;
endpackage

interface strela_mem_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 8
);
    import strela_obi_pkg::*;

    obi_req_t  [NUM_MASTERS-1:0] masters_req;
    obi_resp_t [NUM_MASTERS-1:0] masters_resp;
    obi_req_t                    slave_req;
    obi_resp_t                   slave_resp;

    modport slave  (input  masters_req, slave_resp, output masters_resp, slave_req);
    modport master (output masters_req, slave_resp, input  masters_resp, slave_req);
endinterface

// File: rtl/strela_mem_arbiter.sv
// Round-robin OBI arbiter: shares one memory port among NUM_MASTERS masters and
// routes each response back to its issuer through an in-order ID FIFO.
module strela_mem_arbiter
    import strela_obi_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 8,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    strela_mem_arbiter_if.slave              bus,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
    output logic                             rsp_err_o
);
    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] locked_idx;
    logic             lock;
    logic [IDX_W-1:0] id_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             rsp_err;

    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] head;
    int unsigned      cand;
    logic             found;
    logic             can_issue;
    logic             issue;
    logic             handshake;
    logic             stall;
    logic             pop;

    // A stalled request keeps its slot; otherwise scan upward from the rr pointer.
    always_comb begin : select
        sel      = locked_idx;
        cand     = 0;
        cand_idx = '0;
        found    = 1'b0;
        if (!lock) begin
            sel = rr_ptr;
            for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
                cand = 32'(rr_ptr) + k;
                if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
                cand_idx = IDX_W'(cand);
                if (!found && bus.masters_req[cand_idx].req) begin
                    found = 1'b1;
                    sel   = cand_idx;
                end
            end
        end
    end

    always_comb begin : control
        can_issue = (count < CNT_W'(MAX_OUTSTANDING));
        issue     = can_issue && bus.masters_req[sel].req;
        handshake = issue && bus.slave_resp.gnt;
        stall     = issue && !bus.slave_resp.gnt;
        head      = id_fifo[rd_ptr];
        pop       = bus.slave_resp.rvalid && (count != '0);
    end

    always_comb begin : route
        bus.slave_req    = issue ? bus.masters_req[sel] : '0;
        bus.masters_resp = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            bus.masters_resp[i].gnt    = handshake && (IDX_W'(i) == sel);
            bus.masters_resp[i].rvalid = pop && (IDX_W'(i) == head);
            bus.masters_resp[i].rdata  = bus.slave_resp.rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : arb_state
        if (!rst_ni) begin
            rr_ptr     <= '0;
            lock       <= 1'b0;
            locked_idx <= '0;
        end else if (handshake) begin
            rr_ptr <= (sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel + IDX_W'(1);
            lock   <= 1'b0;
        end else if (stall) begin
            lock       <= 1'b1;
            locked_idx <= sel;
        end else if (lock && !bus.masters_req[locked_idx].req) begin
            lock <= 1'b0;
        end
    end

    // In-order record of granted masters; OBI answers every grant in order.
    always_ff @(posedge clk_i or negedge rst_ni) begin : id_tracking
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rsp_err <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) id_fifo[i] <= '0;
        end else begin
            if (handshake) begin
                id_fifo[wr_ptr] <= sel;
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PTR_W'(1);
            if (handshake && !pop)      count <= count + CNT_W'(1);
            else if (!handshake && pop) count <= count - CNT_W'(1);
            if (bus.slave_resp.rvalid && (count == '0)) rsp_err <= 1'b1;
        end
    end

    assign outstanding_o = count;
    assign rsp_err_o     = rsp_err;
endmodule

// File: tb/tb_strela_mem_arbiter.sv
// Randomised and directed bench for strela_mem_arbiter with a queue-based reference
// model and a response scoreboard checked by an independent monitor.
module tb_strela_mem_arbiter;
    import strela_obi_pkg::*;

    localparam int unsigned N    = 8;
    localparam int unsigned MAXO = 2;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [$clog2(MAXO):0] outstanding_o;
    logic                  rsp_err_o;

    strela_mem_arbiter_if #(.NUM_MASTERS(N)) arb_bus ();

    strela_mem_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .bus           (arb_bus),
        .outstanding_o (outstanding_o),
        .rsp_err_o     (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    // Reference model: arbitration and outstanding-order state.
    int   m_rr = 0;
    bit   m_lock = 1'b0;
    int   m_locked = 0;
    bit   m_err = 1'b0;
    int   m_q[$];

    obi_req_t       seen_req;
    logic [N-1:0]   seen_rv;
    logic [31:0]    seen_rdata;
    logic [$clog2(MAXO):0] seen_out;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int m;
            m = (m_rr + k) % N;
            if (arb_bus.masters_req[m].req) return m;
        end
        return -1;
    endfunction

    task automatic set_req(input int m, input bit r, input logic [31:0] a);
        obi_req_t q;
        q.req   = r;
        q.we    = r ? 1'($urandom_range(1)) : 1'b0;
        q.be    = r ? 4'($urandom) : 4'h0;
        q.addr  = a;
        q.wdata = r ? $urandom : 32'h0;
        arb_bus.masters_req[m] = q;
    endtask

    // One clock cycle: drive slave response, predict, check at negedge, advance model.
    task automatic step(input bit g, input bit rv, input logic [31:0] rd, output bit hs, output int hs_id);
        int           sel;
        bit           iss;
        int           exp_cnt;
        bit           exp_err;
        obi_req_t     exp_req;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] act_gnt;
        arb_bus.slave_resp.gnt    = g;
        arb_bus.slave_resp.rvalid = rv;
        arb_bus.slave_resp.rdata  = rd;
        exp_cnt = m_q.size();
        exp_err = m_err;
        sel     = m_lock ? m_locked : pick();
        iss     = (exp_cnt < MAXO) && (sel >= 0) && arb_bus.masters_req[sel].req;
        exp_req = iss ? arb_bus.masters_req[sel] : '0;
        exp_gnt = (iss && g) ? (N'(1) << sel) : '0;
        if (rv && exp_cnt > 0) sb_q.push_back('{m_q[0], rd});
        @(negedge clk_i);
        for (int i = 0; i < N; i++) act_gnt[i] = arb_bus.masters_resp[i].gnt;
        for (int i = 0; i < N; i++) seen_rv[i] = arb_bus.masters_resp[i].rvalid;
        seen_req   = arb_bus.slave_req;
        seen_rdata = arb_bus.masters_resp[0].rdata;
        seen_out   = outstanding_o;
        check("slave_req", 80'(arb_bus.slave_req), 80'(exp_req));
        check("gnt_vec", 80'(act_gnt), 80'(exp_gnt));
        check("outstanding", 80'(outstanding_o), 80'(exp_cnt));
        check("rsp_err", 80'(rsp_err_o), 80'(exp_err));
        if (rv) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1'b1;
        end
        hs = 1'b0;
        hs_id = -1;
        if (iss && g) begin
            m_q.push_back(sel);
            m_rr   = (sel + 1) % N;
            m_lock = 1'b0;
            hs     = 1'b1;
            hs_id  = sel;
        end else if (iss) begin
            m_lock   = 1'b1;
            m_locked = sel;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h0);
        arb_bus.slave_resp = '0;
        m_rr = 0; m_lock = 1'b0; m_locked = 0; m_err = 1'b0;
        m_q.delete();
        sb_q.delete();
        @(posedge clk_i);
        #1;
        check("reset_outstanding", 80'(outstanding_o), 80'(0));
        check("reset_rsp_err", 80'(rsp_err_o), 80'(0));
        check("reset_slave_req", 80'(arb_bus.slave_req.req), 80'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // Response monitor: every master rvalid must match the oldest expected response.
    initial begin
        forever begin
            @(negedge clk_i);
            for (int i = 0; i < N; i++) begin
                if (arb_bus.masters_resp[i].rvalid) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_unexpected: master %0d got rvalid, expected none", i);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("rsp_id", 80'(i), 80'(e.id));
                        check("rsp_rdata", 80'(arb_bus.masters_resp[i].rdata), 80'(e.data));
                        check("rsp_bcast", 80'(arb_bus.masters_resp[(i + 1) % N].rdata), 80'(e.data));
                    end
                end
            end
            if (sb_q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL rsp_missing: got no rvalid, expected master %0d", sb_q[0].id);
                sb_q.delete();
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hs;
        int id;
        int order [6] = '{0, 2, 5, 0, 2, 5};
        arb_bus.slave_resp = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h0);
        do_reset();

        // Round robin among 0, 2, 5.
        set_req(0, 1'b1, 32'h10); set_req(2, 1'b1, 32'h20); set_req(5, 1'b1, 32'h50);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, k > 0, $urandom, hs, id);
            check("rr_order", 80'(id), 80'(order[k]));
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h0);
        step(1'b0, 1'b1, $urandom, hs, id);

        // Stalled master 3 keeps the port while master 1 waits.
        set_req(3, 1'b1, 32'h100);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) set_req(1, 1'b1, 32'h200);
            step(1'b0, 1'b0, 32'h0, hs, id);
            check("stall_addr", 80'(seen_req.addr), 80'(32'h100));
            check("stall_req", 80'(seen_req.req), 80'(1));
        end
        step(1'b1, 1'b0, 32'h0, hs, id);
        check("stall_gnt3", 80'(id), 80'(3));
        set_req(3, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, hs, id);
        check("after_stall_gnt1", 80'(id), 80'(1));
        set_req(1, 1'b0, 32'h0);

        // Full: no issue until a response frees a slot.
        set_req(6, 1'b1, 32'h600);
        step(1'b1, 1'b0, 32'h0, hs, id);
        check("full_no_req", 80'(seen_req.req), 80'(0));
        check("full_count", 80'(seen_out), 80'(2));
        step(1'b1, 1'b1, 32'h1234, hs, id);
        check("full_pop_no_bypass", 80'(hs), 80'(0));
        step(1'b1, 1'b0, 32'h0, hs, id);
        check("issue_after_pop", 80'(id), 80'(6));
        set_req(6, 1'b0, 32'h0);
        step(1'b0, 1'b1, $urandom, hs, id);
        step(1'b0, 1'b1, $urandom, hs, id);

        // Responses return in grant order: 4 then 1.
        set_req(4, 1'b1, 32'h400);
        step(1'b1, 1'b0, 32'h0, hs, id);
        check("gnt4", 80'(id), 80'(4));
        set_req(4, 1'b0, 32'h0);
        set_req(1, 1'b1, 32'h104);
        step(1'b1, 1'b0, 32'h0, hs, id);
        check("gnt1", 80'(id), 80'(1));
        set_req(1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hAAAA, hs, id);
        check("rv_to4", 80'(seen_rv), 80'(8'h10));
        check("rdata_aaaa", 80'(seen_rdata), 80'(32'hAAAA));
        step(1'b0, 1'b1, 32'hBBBB, hs, id);
        check("rv_to1", 80'(seen_rv), 80'(8'h02));
        check("drained", 80'(outstanding_o), 80'(0));

        // Push and pop in the same cycle.
        set_req(2, 1'b1, 32'h204);
        step(1'b1, 1'b0, 32'h0, hs, id);
        set_req(2, 1'b1, 32'h208);
        step(1'b1, 1'b1, 32'hCCCC, hs, id);
        check("pushpop_rv", 80'(seen_rv), 80'(8'h04));
        check("pushpop_count", 80'(outstanding_o), 80'(1));
        set_req(2, 1'b0, 32'h0);
        step(1'b0, 1'b1, $urandom, hs, id);

        // Spurious rvalid is sticky; reset clears it and drops in-flight IDs.
        step(1'b0, 1'b1, 32'hDEAD, hs, id);
        check("err_set", 80'(rsp_err_o), 80'(1));
        step(1'b0, 1'b0, 32'h0, hs, id);
        check("err_sticky", 80'(rsp_err_o), 80'(1));
        set_req(0, 1'b1, 32'h0); set_req(7, 1'b1, 32'h700);
        step(1'b1, 1'b0, 32'h0, hs, id);
        step(1'b1, 1'b0, 32'h0, hs, id);
        do_reset();
        step(1'b0, 1'b1, 32'hBEEF, hs, id);
        check("err_after_reset", 80'(rsp_err_o), 80'(1));
        do_reset();

        // Random traffic under OBI rules: masters hold req until granted.
        for (int c = 0; c < 3000; c++) begin
            bit g;
            bit rv;
            for (int i = 0; i < N; i++)
                if (!arb_bus.masters_req[i].req && $urandom_range(9) < 3) set_req(i, 1'b1, $urandom);
            g  = ($urandom_range(3) != 0);
            rv = (m_q.size() > 0) ? 1'($urandom_range(1)) : ($urandom_range(199) == 0);
            step(g, rv, $urandom, hs, id);
            if (hs) begin
                if ($urandom_range(1) == 0) set_req(id, 1'b0, 32'h0);
                else set_req(id, 1'b1, $urandom);
            end
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h0);
        for (int k = 0; k < MAXO + 1; k++) step(1'b0, m_q.size() > 0, $urandom, hs, id);
        check("final_drain", 80'(outstanding_o), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
